// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - I2C slave exposing a byte register file with pointer, bursts and write strobe
// Optional build macro I2C_AUTO_INC_EN: pointer advances after each written or ACKed read byte.
module i2c_reg_slave #(
    parameter logic [6:0] I2C_ADDRESS      = 7'h20,
    parameter int         NOF_DATA_WORDS   = 4,
    parameter int         NOF_ADDRESS_BITS = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          sda_o,
    output logic [NOF_DATA_WORDS*8-1:0]   data_o,
    output logic                          wr_strobe_o,
    output logic [NOF_ADDRESS_BITS-1:0]   wr_addr_o,
    output logic                          busy_o
);

`ifdef I2C_AUTO_INC_EN
    localparam logic AUTO_INC = 1'b1;
`else
    localparam logic AUTO_INC = 1'b0;
`endif

    localparam logic [NOF_ADDRESS_BITS:0]   NOF_W    = (NOF_ADDRESS_BITS+1)'(NOF_DATA_WORDS);
    localparam logic [NOF_ADDRESS_BITS-1:0] LAST_IDX = NOF_ADDRESS_BITS'(NOF_DATA_WORDS-1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
    } state_t;

    // [0] metastability flop, [1] synchronised value, [2] previous synchronised value
    logic [2:0] scl_sync_q, sda_sync_q;

    state_t                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [7:0]                  rx_q, rx_d;
    logic [7:0]                  tx_q, tx_d;
    logic [NOF_ADDRESS_BITS-1:0] ptr_q, ptr_d;
    logic                        ack_q, ack_d;
    logic                        sda_q, sda_d;
    logic [7:0]                  regs_q [NOF_DATA_WORDS];
    logic [7:0]                  regs_d [NOF_DATA_WORDS];
    logic                        strobe_q, strobe_d;
    logic [NOF_ADDRESS_BITS-1:0] waddr_q, waddr_d;
    logic                        busy_q, busy_d;

    logic                        scl_rise, scl_fall, start_det, stop_det, sda_s;
    logic                        in_range;
    logic [7:0]                  rx_byte, rd_byte;
    logic [NOF_ADDRESS_BITS-1:0] ptr_inc;

    assign sda_s     = sda_sync_q[1];
    assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
    assign start_det =  scl_sync_q[1] &  scl_sync_q[2] & ~sda_sync_q[1] &  sda_sync_q[2];
    assign stop_det  =  scl_sync_q[1] &  scl_sync_q[2] &  sda_sync_q[1] & ~sda_sync_q[2];

    assign in_range = {1'b0, ptr_q} < NOF_W;
    assign rx_byte  = {rx_q[6:0], sda_s};
    assign rd_byte  = in_range ? regs_q[ptr_q] : 8'h00;
    assign ptr_inc  = (ptr_q >= LAST_IDX) ? '0 : ptr_q + NOF_ADDRESS_BITS'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        ptr_d    = ptr_q;
        ack_d    = ack_q;
        sda_d    = sda_q;
        regs_d   = regs_q;
        strobe_d = 1'b0;
        waddr_d  = waddr_q;
        busy_d   = busy_q;

        if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            sda_d   = 1'b1;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        rx_d  = rx_byte;
                        cnt_d = cnt_q + 4'd1;
                        // Pointer and register updates happen on the 8th SCL rise
                        if (cnt_q == 4'd7 && state_q == S_PTR) begin
                            ptr_d = rx_byte[NOF_ADDRESS_BITS-1:0];
                        end else if (cnt_q == 4'd7 && state_q == S_WDATA) begin
                            if (in_range) begin
                                regs_d[ptr_q] = rx_byte;
                                strobe_d      = 1'b1;
                                waddr_d       = ptr_q;
                            end
                            if (AUTO_INC) ptr_d = ptr_inc;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        sda_d = 1'b0;
                        case (state_q)
                            S_ADDR: begin
                                if (rx_q[7:1] == I2C_ADDRESS) begin
                                    state_d = S_ADDR_ACK;
                                end else begin
                                    state_d = S_WAIT;
                                    sda_d   = 1'b1;
                                end
                            end
                            S_PTR:   state_d = S_PTR_ACK;
                            default: state_d = S_WDATA_ACK;
                        endcase
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (rx_q[0]) begin
                            state_d = S_RDATA;
                            sda_d   = rd_byte[7];
                            tx_d    = {rd_byte[6:0], 1'b0};
                        end else begin
                            state_d = S_PTR;
                            sda_d   = 1'b1;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d = S_WDATA;
                        cnt_d   = 4'd0;
                        sda_d   = 1'b1;
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = S_RDATA_ACK;
                            cnt_d   = 4'd0;
                            sda_d   = 1'b1;
                        end else begin
                            sda_d = tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_s;
                        if (!sda_s && AUTO_INC) ptr_d = ptr_inc;
                    end else if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (!ack_q) begin
                            state_d = S_RDATA;
                            sda_d   = rd_byte[7];
                            tx_d    = {rd_byte[6:0], 1'b0};
                        end else begin
                            state_d = S_WAIT;
                            sda_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronisers reset to the idle-bus level so release of reset creates no edges
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= '0;
            ack_q      <= 1'b1;
            sda_q      <= 1'b1;
            for (int i = 0; i < NOF_DATA_WORDS; i++) regs_q[i] <= 8'h00;
            strobe_q   <= 1'b0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_i};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            sda_q      <= sda_d;
            regs_q     <= regs_d;
            strobe_q   <= strobe_d;
            waddr_q    <= waddr_d;
            busy_q     <= busy_d;
        end
    end

    for (genvar k = 0; k < NOF_DATA_WORDS; k++) begin : g_img
        assign data_o[8*k +: 8] = regs_q[k];
    end

    assign sda_o       = sda_q;
    assign wr_strobe_o = strobe_q;
    assign wr_addr_o   = waddr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb/tb_i2c_reg_slave.sv - directed I2C master bench with a transaction-level register model
module tb_i2c_reg_slave;
    localparam int N = 4;
    localparam int T = 8;
    localparam int K_ADDR = 0, K_PTR = 1, K_DATA = 2, K_IGN = 3;
`ifdef I2C_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
    logic sda_o, wr_strobe, busy;
    logic [N*8-1:0] data_o;
    logic [1:0] wr_addr;
    wire sda_bus = sda_m & sda_o;

    int tests_run = 0, tests_failed = 0;
    logic [7:0] m_mem [N];
    int m_ptr = 0, m_strobes = 0, m_last_addr = 0;
    int strobes = 0;
    logic [1:0] last_addr = 2'd0;
    bit cmp_en = 1'b0;
    int cmp_fails = 0;

    always #5 clk = ~clk;

    i2c_reg_slave #(.I2C_ADDRESS(7'h20), .NOF_DATA_WORDS(N), .NOF_ADDRESS_BITS(2)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .scl_i(scl), .sda_i(sda_bus), .sda_o(sda_o),
        .data_o(data_o), .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr), .busy_o(busy)
    );

    function automatic logic [N*8-1:0] img();
        logic [N*8-1:0] v;
        for (int k = 0; k < N; k++) v[8*k +: 8] = m_mem[k];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobes++;
            last_addr = wr_addr;
        end
        if (cmp_en && cmp_fails < 5) begin
            tests_run++;
            if (data_o !== img()) begin
                tests_failed++;
                cmp_fails++;
                $display("FAIL data_o_vs_model: got %h, expected %h", data_o, img());
            end
        end
    end

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_c();
        sda_m = 1'b1; wt(T); scl = 1'b1; wt(T); sda_m = 1'b0; wt(T); scl = 1'b0; wt(T);
        check("busy_after_start", busy, 1);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wt(T); scl = 1'b1; wt(T); sda_m = 1'b1; wt(T);
        check("busy_after_stop", busy, 0);
        check("sda_released_after_stop", sda_o, 1);
    endtask

    task automatic bit_c(input logic b, output logic r);
        sda_m = b; wt(T); scl = 1'b1; wt(T); r = sda_bus; scl = 1'b0; wt(T);
    endtask

    task automatic wr_byte(input logic [7:0] b, input int kind);
        logic r, ack, exp_ack;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) cmp_en = 1'b0;
            bit_c(b[i], r);
        end
        bit_c(1'b1, ack);
        exp_ack = (kind == K_ADDR) ? (b[7:1] != 7'h20) : (kind == K_IGN);
        check("ack_bit", ack, exp_ack);
        if (kind == K_PTR) m_ptr = b % N;
        if (kind == K_DATA) begin
            if (m_ptr < N) begin
                m_mem[m_ptr] = b;
                m_strobes++;
                m_last_addr = m_ptr;
            end
            if (AUTO) m_ptr = (m_ptr + 1) % N;
        end
        cmp_en = 1'b1;
    endtask

    task automatic rd_byte(input logic last, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_c(1'b1, r);
            v[i] = r;
        end
        check("read_byte", v, (m_ptr < N) ? m_mem[m_ptr] : 8'h00);
        bit_c(last, r);
        if (!last && AUTO) m_ptr = (m_ptr + 1) % N;
    endtask

    task automatic write_txn(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1, input int n);
        start_c();
        wr_byte(8'h40, K_ADDR);
        wr_byte(ptr, K_PTR);
        wr_byte(d0, K_DATA);
        if (n > 1) wr_byte(d1, K_DATA);
        stop_c();
    endtask

    initial begin
        logic [7:0] v0, v1;
        logic r;
        int s0;
        for (int k = 0; k < N; k++) m_mem[k] = 8'h00;

        wt(3);
        check("reset_sda_o", sda_o, 1);
        check("reset_data_o", data_o, 0);
        check("reset_strobe", wr_strobe, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        wt(4);
        cmp_en = 1'b1;

        // single write to register 1
        write_txn(8'h01, 8'hA5, 8'h00, 1);
        check("t1_word1", data_o[15:8], 8'hA5);
        check("t1_strobes", strobes, 1);
        check("t1_wr_addr", last_addr, 1);

        // two-byte burst starting at the last register
        s0 = strobes;
        write_txn(8'h03, 8'h11, 8'h22, 2);
        check("t2_strobes", strobes - s0, 2);
        check("t2_wr_addr_vs_model", last_addr, m_last_addr);
`ifdef I2C_AUTO_INC_EN
        check("t2_word3", data_o[31:24], 8'h11);
        check("t2_word0_wrap", data_o[7:0], 8'h22);
`else
        check("t2_word3", data_o[31:24], 8'h22);
        check("t2_word0_untouched", data_o[7:0], 8'h00);
`endif

        // pointer write, repeated START, two-byte read
        write_txn(8'h02, 8'h5C, 8'h77, 2);
        start_c();
        wr_byte(8'h40, K_ADDR);
        wr_byte(8'h02, K_PTR);
        start_c();
        wr_byte(8'h41, K_ADDR);
        rd_byte(1'b0, v0);
        rd_byte(1'b1, v1);
        stop_c();
`ifdef I2C_AUTO_INC_EN
        check("t3_read0", v0, 8'h5C);
        check("t3_read1", v1, 8'h77);
`else
        check("t3_read0", v0, 8'h77);
        check("t3_read1", v1, 8'h77);
`endif

        // foreign address: every byte left un-ACKed, nothing written
        s0 = strobes;
        start_c();
        wr_byte(8'h42, K_ADDR);
        wr_byte(8'h00, K_IGN);
        wr_byte(8'hFF, K_IGN);
        stop_c();
        check("t4_strobes", strobes - s0, 0);
        check("t4_word1", data_o[15:8], 8'hA5);

        // STOP after four data bits
        s0 = strobes;
        start_c();
        wr_byte(8'h40, K_ADDR);
        wr_byte(8'h01, K_PTR);
        bit_c(1'b0, r); bit_c(1'b1, r); bit_c(1'b1, r); bit_c(1'b0, r);
        stop_c();
        check("t5_strobes", strobes - s0, 0);
        check("t5_word1", data_o[15:8], 8'hA5);
        write_txn(8'h01, 8'hC3, 8'h00, 1);
        check("t5_recover_word1", data_o[15:8], 8'hC3);

        // reset while the slave is driving a read byte
        write_txn(8'h00, 8'h0F, 8'h00, 1);
        start_c();
        wr_byte(8'h40, K_ADDR);
        wr_byte(8'h00, K_PTR);
        start_c();
        wr_byte(8'h41, K_ADDR);
        for (int i = 7; i >= 5; i--) begin
            bit_c(1'b1, r);
            check("t6_partial_bit", r, m_mem[m_ptr][i]);
        end
        wt(2);
        check("t6_sda_driving", sda_o, m_mem[m_ptr][4]);
        cmp_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_sda_async_release", sda_o, 1);
        check("t6_data_cleared", data_o, 0);
        check("t6_busy_cleared", busy, 0);
        scl = 1'b1; wt(2); sda_m = 1'b1; wt(2);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) m_mem[k] = 8'h00;
        m_ptr = 0;
        wt(4);
        cmp_en = 1'b1;
        write_txn(8'h00, 8'h5A, 8'h00, 1);
        check("t6_after_reset_word0", data_o[7:0], 8'h5A);
        check("t6_after_reset_wr_addr", last_addr, 0);
        check("total_strobes_vs_model", strobes, m_strobes);

        cmp_en = 1'b0;
        wt(4);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
